tia_hsync_decode: RTL and testbench
===================================

Name: tia_hsync_decode

Overview:
Horizontal timing generator for the TIA model. It divides the colour clock by 4 and steps a 6-bit polynomial (LFSR) horizontal counter with a 57-step line. It decodes fixed counter states into active-low set/reset strobes that drive the tia_f3 SR latches (HSYNC, HBLANK, colour burst, centre). It sits directly upstream of those latches; its strobes connect to their s1/r1 inputs.

Parameters:
STEP_CLOCKS, 4, colour clocks per counter step (one H1/H2 phase cycle)
LINE_STEPS, 57, counter steps per scanline; the counter wraps to step 0 after step LINE_STEPS-1

Ports:
clock  input  1  colour clock; all state changes on posedge
reset  input  1  synchronous, active-high
rsync  input  1  single-clock strobe; restarts the line at step 0
hmove_late  input  1  selects late HBLANK reset (step 18 instead of 16)
shb_n  output  1  set-HBLANK strobe, active-low
shs_n  output  1  set-HSYNC strobe, active-low
rhs_n  output  1  reset-HSYNC strobe, active-low
rcb_n  output  1  reset-colour-burst strobe, active-low
rhb_n  output  1  reset-HBLANK strobe, active-low
cnt_n  output  1  centre-of-line strobe, active-low
hcount  output  6  current LFSR state
phase  output  2  colour-clock phase within the step, 0..STEP_CLOCKS-1
line_start  output  1  high for the single clock where step 0 / phase 0 is presented

Behaviour:
- Reset (synchronous, high at a posedge): hcount=6'b000000, phase=0, and step 0 phase 0 is presented on the next cycle. shb_n=0 and line_start=1 in that first cycle. All other strobes =1.
- Phase: increments each clock. At STEP_CLOCKS-1 it wraps to 0 and the LFSR advances.
- LFSR advance: next = {hcount[0] XNOR hcount[1], hcount[5:1]}. Step k is the state reached k advances from 000000. Sequence starts 000000, 100000, 110000, 111000, …
- Wrap: when phase=STEP_CLOCKS-1 and hcount is the state of step LINE_STEPS-1 (56), the next state is 000000, not the LFSR successor. The line is therefore 57×4=228 clocks.
- Decoded steps:
  - shb_n: step 0
  - shs_n: step 4
  - rhs_n: step 8
  - rcb_n: step 12
  - rhb_n: step 16 when hmove_late=0; step 18 when hmove_late=1
  - cnt_n: step 36
- Strobe timing: each strobe is low for all STEP_CLOCKS clocks of its step (phases 0..3) and high otherwise.
  - The strobe is combinationally decoded from registered hcount, so it has zero latency relative to hcount.
  - hmove_late is sampled combinationally. A change mid-step takes effect on the same cycle.
- rsync high at a posedge forces hcount=000000 and phase=0 on the next cycle, exactly as reset does. It may arrive in any phase or step.
- rsync coinciding with the natural wrap gives the same result: one step 0, no double line_start.
- reset takes priority over rsync. rsync held high repeatedly re-presents step 0 / phase 0; line_start stays high each of those cycles.
- No strobe pair for the same latch is ever low simultaneously. Set and reset steps are distinct.

Decomposition:
- Package tia_hctr_pkg holds:
  - step constants: STEP_SHB=0, STEP_SHS=4, STEP_RHS=8, STEP_RCB=12, STEP_RHB=16, STEP_LRHB=18, STEP_CNT=36, STEP_END=56
  - the matching 6-bit LFSR pattern constants, precomputed from the advance rule
  - the XNOR advance as a function shared with the bench model
- Sub-module tia_lfsr6: 6-bit LFSR with synchronous load-zero and an advance enable.
- tia_hsync_decode holds the phase counter, wrap/rsync logic and decode.

Test Plan:
- Release reset at clock 0: shb_n low clocks 0–3, shs_n 16–19, rhs_n 32–35, rcb_n 48–51, rhb_n 64–67, cnt_n 144–147. line_start high at clocks 0 and 228 only.
- hcount trace from reset: 000000 (clk 0–3), 100000 (4–7), 110000 (8–11), 111000 (12–15). At clock 224 it holds the step-56 pattern; clock 228 it returns to 000000.
- hmove_late=1 held: rhb_n low clocks 72–75, not 64–67. Toggling hmove_late during step 16 moves rhb_n low/high in the same cycle.
- rsync pulsed at clock 100 (step 25, phase 0):
  - clock 101: hcount=000000, phase=0, shb_n low clocks 101–104, line_start=1 at clock 101
  - next shs_n low clocks 117–120
- rsync pulsed at clock 227 (the natural wrap): single step 0 at clock 228, identical to no rsync.
- reset and rsync asserted together mid-line: step 0 next cycle. Reset held 3 clocks: shb_n low and all other strobes high throughout, phase stuck at 0.

Source files
------------

// File: rtl/tia_hctr_pkg.sv
// Shared constants and helpers for the TIA horizontal counter: step numbers,
// the LFSR patterns they correspond to, and the polynomial advance rule.
package tia_hctr_pkg;

  localparam int STEP_CLOCKS_DEF = 4;
  localparam int LINE_STEPS_DEF  = 57;

  // Step numbers of the decoded events within a line
  localparam int STEP_SHB  = 0;
  localparam int STEP_SHS  = 4;
  localparam int STEP_RHS  = 8;
  localparam int STEP_RCB  = 12;
  localparam int STEP_RHB  = 16;
  localparam int STEP_LRHB = 18;
  localparam int STEP_CNT  = 36;
  localparam int STEP_END  = 56;

  // LFSR states reached after the given number of advances from 000000
  localparam logic [5:0] PAT_SHB  = 6'b000000;
  localparam logic [5:0] PAT_SHS  = 6'b111100;
  localparam logic [5:0] PAT_RHS  = 6'b110111;
  localparam logic [5:0] PAT_RCB  = 6'b001111;
  localparam logic [5:0] PAT_RHB  = 6'b011100;
  localparam logic [5:0] PAT_LRHB = 6'b010111;
  localparam logic [5:0] PAT_CNT  = 6'b101100;
  localparam logic [5:0] PAT_END  = 6'b010100;

  // Index of each strobe within the decode vector
  localparam int SEL_SHB = 0;
  localparam int SEL_SHS = 1;
  localparam int SEL_RHS = 2;
  localparam int SEL_RCB = 3;
  localparam int SEL_RHB = 4;
  localparam int SEL_CNT = 5;
  localparam int NUM_STROBES = 6;

  // Polynomial advance: XNOR of the two low bits shifts in at the top
  function automatic logic [5:0] lfsr_advance(input logic [5:0] h);
    return {~(h[0] ^ h[1]), h[5:1]};
  endfunction

  // State reached after n advances from 000000 (elaboration-time use)
  function automatic logic [5:0] lfsr_pattern(input int n);
    logic [5:0] h;
    h = 6'b000000;
    for (int i = 0; i < n; i++) h = lfsr_advance(h);
    return h;
  endfunction

endpackage

// File: rtl/tia_lfsr6.sv
// 6-bit polynomial counter with synchronous load-to-zero and advance enable.
module tia_lfsr6
  import tia_hctr_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       load_zero,
  input  logic       advance,
  output logic [5:0] state
);

  logic [5:0] state_reg;
  logic [5:0] state_next;

  // Load-zero overrides the advance so a restart always lands on step 0
  always_comb begin
    state_next = state_reg;
    if (load_zero)
      state_next = 6'b000000;
    else if (advance)
      state_next = lfsr_advance(state_reg);
  end

  // State register
  always_ff @(posedge clock) begin
    if (reset)
      state_reg <= 6'b000000;
    else
      state_reg <= state_next;
  end

  assign state = state_reg;

endmodule

// File: rtl/tia_hsync_decode.sv
// Horizontal timing generator: divides the colour clock into steps, runs the
// LFSR line counter and decodes the active-low set/reset strobes.
module tia_hsync_decode
  import tia_hctr_pkg::*;
#(
  parameter int STEP_CLOCKS = STEP_CLOCKS_DEF,
  parameter int LINE_STEPS  = LINE_STEPS_DEF
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rsync,
  input  logic       hmove_late,
  output logic       shb_n,
  output logic       shs_n,
  output logic       rhs_n,
  output logic       rcb_n,
  output logic       rhb_n,
  output logic       cnt_n,
  output logic [5:0] hcount,
  output logic [1:0] phase,
  output logic       line_start
);

  // Last state of the line, derived from the line length so the two agree
  localparam logic [5:0] END_PAT   = lfsr_pattern(LINE_STEPS - 1);
  localparam logic [1:0] LAST_PHASE = 2'(STEP_CLOCKS - 1);

  logic [1:0] phase_reg;
  logic [1:0] phase_next;
  logic [5:0] hcount_w;
  logic       phase_last;
  logic       line_wrap;
  logic       load_zero;
  logic [5:0] dec_pat [NUM_STROBES];
  logic [NUM_STROBES-1:0] strobe_n;

  assign phase_last = (phase_reg == LAST_PHASE);
  assign line_wrap  = phase_last && (hcount_w == END_PAT);
  // rsync and the natural wrap both land on step 0, so coinciding is harmless
  assign load_zero  = rsync || line_wrap;

  tia_lfsr6 u_lfsr (
    .clock     (clock),
    .reset     (reset),
    .load_zero (load_zero),
    .advance   (phase_last),
    .state     (hcount_w)
  );

  // Phase within the step: rsync restarts, otherwise count and wrap
  always_comb begin
    phase_next = phase_reg + 2'd1;
    if (rsync || phase_last)
      phase_next = 2'd0;
  end

  // Phase register
  always_ff @(posedge clock) begin
    if (reset)
      phase_reg <= 2'd0;
    else
      phase_reg <= phase_next;
  end

  // Pattern each strobe decodes; HBLANK reset moves with hmove_late
  always_comb begin
    dec_pat[SEL_SHB] = PAT_SHB;
    dec_pat[SEL_SHS] = PAT_SHS;
    dec_pat[SEL_RHS] = PAT_RHS;
    dec_pat[SEL_RCB] = PAT_RCB;
    dec_pat[SEL_RHB] = hmove_late ? PAT_LRHB : PAT_RHB;
    dec_pat[SEL_CNT] = PAT_CNT;
  end

  // Each strobe is low for the whole step whose state matches its pattern
  genvar gi;
  generate
    for (gi = 0; gi < NUM_STROBES; gi++) begin : g_dec
      assign strobe_n[gi] = (hcount_w != dec_pat[gi]);
    end
  endgenerate

  assign shb_n = strobe_n[SEL_SHB];
  assign shs_n = strobe_n[SEL_SHS];
  assign rhs_n = strobe_n[SEL_RHS];
  assign rcb_n = strobe_n[SEL_RCB];
  assign rhb_n = strobe_n[SEL_RHB];
  assign cnt_n = strobe_n[SEL_CNT];

  assign hcount     = hcount_w;
  assign phase      = phase_reg;
  // Step 0 is the only line position with the all-zero state
  assign line_start = (hcount_w == PAT_SHB) && (phase_reg == 2'd0);

endmodule

// File: tb/tb_tia_hsync_decode.sv
// Self-checking bench for tia_hsync_decode: a step/phase model pushes the
// expected outputs per clock into a queue, each test pops and compares.
module tb_tia_hsync_decode;
  import tia_hctr_pkg::*;

  typedef struct packed {
    logic [5:0] hc;
    logic [1:0] ph;
    logic       ls;
    logic [5:0] str;   // shb,shs,rhs,rcb,rhb,cnt (active-low)
  } obs_t;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       rsync = 1'b0;
  logic       hmove_late = 1'b0;
  logic       shb_n, shs_n, rhs_n, rcb_n, rhb_n, cnt_n;
  logic [5:0] hcount;
  logic [1:0] phase;
  logic       line_start;

  int vectors = 0;
  int miscompares = 0;
  int m_step = 0;
  int m_phase = 0;
  int clk_idx = 0;
  obs_t exp_q[$];

  tia_hsync_decode dut (
    .clock      (clock),
    .reset      (reset),
    .rsync      (rsync),
    .hmove_late (hmove_late),
    .shb_n      (shb_n),
    .shs_n      (shs_n),
    .rhs_n      (rhs_n),
    .rcb_n      (rcb_n),
    .rhb_n      (rhb_n),
    .cnt_n      (cnt_n),
    .hcount     (hcount),
    .phase      (phase),
    .line_start (line_start)
  );

  always #5 clock = ~clock;

  function automatic obs_t model_out();
    obs_t o;
    logic [5:0] h;
    int rhb_step;
    h = 6'b000000;
    for (int i = 0; i < m_step; i++) h = lfsr_advance(h);
    rhb_step = hmove_late ? 18 : 16;
    o.hc  = h;
    o.ph  = 2'(m_phase);
    o.ls  = (m_step == 0) && (m_phase == 0);
    o.str = {m_step != 0, m_step != 4, m_step != 8, m_step != 12,
             m_step != rhb_step, m_step != 36};
    return o;
  endfunction

  function automatic obs_t dut_out();
    obs_t o;
    o.hc  = hcount;
    o.ph  = phase;
    o.ls  = line_start;
    o.str = {shb_n, shs_n, rhs_n, rcb_n, rhb_n, cnt_n};
    return o;
  endfunction

  // Apply inputs for one clock, advance the model, queue the expectation
  task automatic step(input logic r, input logic s, input logic h);
    reset = r;
    rsync = s;
    hmove_late = h;
    @(posedge clock);
    if (r || s) begin
      m_step = 0;
      m_phase = 0;
      clk_idx = 0;
    end else begin
      clk_idx++;
      if (m_phase == 3) begin
        m_phase = 0;
        m_step = (m_step == 56) ? 0 : m_step + 1;
      end else begin
        m_phase++;
      end
    end
    exp_q.push_back(model_out());
    #1;
  endtask

  task automatic test_reset();
    obs_t got, exp;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 1'b0);
      got = dut_out(); exp = exp_q.pop_front(); vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL reset_hold cyc=%0d got=%h want=%h", i, got, exp);
      end
    end
    $display("test_reset: reset held 3 clocks checked");
  endtask

  task automatic test_line();
    obs_t got, exp;
    step(1'b1, 1'b0, 1'b0);
    got = dut_out(); exp = exp_q.pop_front(); vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL line_clk0 got=%h want=%h", got, exp);
    end
    for (int c = 1; c < 2 * 228 + 8; c++) begin
      step(1'b0, 1'b0, 1'b0);
      got = dut_out(); exp = exp_q.pop_front(); vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL line clk=%0d got=%h want=%h", c, got, exp);
      end
      if (c == 4 || c == 8 || c == 12) begin
        logic [5:0] lit;
        lit = (c == 4) ? 6'b100000 : (c == 8) ? 6'b110000 : 6'b111000;
        vectors++;
        if (hcount !== lit) begin
          miscompares++;
          $display("FAIL hcount_trace clk=%0d got=%b want=%b", c, hcount, lit);
        end
      end
    end
    $display("test_line: two full lines checked");
  endtask

  task automatic test_hmove_late();
    obs_t got, exp;
    step(1'b1, 1'b0, 1'b1);
    void'(exp_q.pop_front());
    for (int c = 1; c < 228; c++) begin
      step(1'b0, 1'b0, 1'b1);
      got = dut_out(); exp = exp_q.pop_front(); vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL hmove_late clk=%0d got=%h want=%h", c, got, exp);
      end
    end
    // Toggle during step 16: rhb_n must follow within the same cycle
    step(1'b1, 1'b0, 1'b0);
    void'(exp_q.pop_front());
    for (int c = 1; c <= 65; c++) begin
      step(1'b0, 1'b0, 1'b0);
      void'(exp_q.pop_front());
    end
    for (int t = 0; t < 4; t++) begin
      hmove_late = ~hmove_late;
      #1;
      exp_q.push_back(model_out());
      got = dut_out(); exp = exp_q.pop_front(); vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL hmove_toggle t=%0d got=%h want=%h", t, got, exp);
      end
    end
    $display("test_hmove_late: late HBLANK reset and live toggle checked");
  endtask

  task automatic test_rsync_mid();
    obs_t got, exp;
    step(1'b1, 1'b0, 1'b0);
    void'(exp_q.pop_front());
    for (int c = 1; c < 260; c++) begin
      // rsync high during clock 100 restarts the line at clock 101
      step(1'b0, c == 101, 1'b0);
      got = dut_out(); exp = exp_q.pop_front(); vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL rsync_mid clk=%0d got=%h want=%h", c, got, exp);
      end
      if (c == 101) begin
        vectors++;
        if (line_start !== 1'b1 || shb_n !== 1'b0) begin
          miscompares++;
          $display("FAIL rsync_restart got ls=%b shb_n=%b want ls=1 shb_n=0",
                   line_start, shb_n);
        end
      end
    end
    $display("test_rsync_mid: rsync at clock 100 checked");
  endtask

  task automatic test_rsync_wrap();
    obs_t got, exp;
    int starts;
    starts = 0;
    step(1'b1, 1'b0, 1'b0);
    void'(exp_q.pop_front());
    for (int c = 1; c < 240; c++) begin
      step(1'b0, c == 228, 1'b0);
      got = dut_out(); exp = exp_q.pop_front(); vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL rsync_wrap clk=%0d got=%h want=%h", c, got, exp);
      end
      if (line_start === 1'b1) starts++;
    end
    vectors++;
    if (starts != 1) begin
      miscompares++;
      $display("FAIL rsync_wrap_starts got=%0d want=1", starts);
    end
    $display("test_rsync_wrap: rsync on natural wrap checked");
  endtask

  task automatic test_back_to_back();
    obs_t got, exp;
    step(1'b1, 1'b0, 1'b0);
    void'(exp_q.pop_front());
    for (int c = 1; c < 70; c++) begin
      step(1'b0, 1'b0, 1'b0);
      void'(exp_q.pop_front());
    end
    for (int c = 0; c < 5; c++) begin
      step(1'b0, 1'b1, 1'b0);
      got = dut_out(); exp = exp_q.pop_front(); vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL rsync_held cyc=%0d got=%h want=%h", c, got, exp);
      end
    end
    for (int c = 0; c < 90; c++) begin
      step(1'b0, 1'b0, 1'b0);
      got = dut_out(); exp = exp_q.pop_front(); vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL after_held cyc=%0d got=%h want=%h", c, got, exp);
      end
    end
    step(1'b1, 1'b1, 1'b0);
    got = dut_out(); exp = exp_q.pop_front(); vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL reset_rsync got=%h want=%h", got, exp);
    end
    for (int c = 0; c < 20; c++) begin
      step(1'b0, 1'b0, 1'b0);
      got = dut_out(); exp = exp_q.pop_front(); vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL after_reset_rsync cyc=%0d got=%h want=%h", c, got, exp);
      end
    end
    $display("test_back_to_back: held rsync and reset+rsync checked");
  endtask

  initial begin
    #2;
    test_reset();
    test_line();
    test_hmove_late();
    test_rsync_mid();
    test_rsync_wrap();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
